// File: rtl/mod_n_sync_counter_pkg.sv
// Shared mode constants and modulus helper for the modulo-N synchronous counter.
// MODULUS of 0 selects the full binary range of the counter width.
package mod_n_sync_counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    function automatic int eff_modulus(input int width, input int modulus);
        return (modulus == 0) ? (1 << width) : modulus;
    endfunction

endpackage

// File: rtl/mod_n_sync_counter_jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
// One instance per counter bit.
module mod_n_sync_counter_jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mod_n_sync_counter.sv
// Modulo-N up/down counter built from per-bit JK cells with common-clock toggle logic.
// Supports load with range check, wrap or saturate at the ends, and a terminal-count flag.
module mod_n_sync_counter
    import mod_n_sync_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err
);

    localparam int               EFF_MOD = eff_modulus(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(EFF_MOD - 1);

    generate
        if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
            $error("mod_n_sync_counter: WIDTH %0d out of range", WIDTH);
        end
        if (MODULUS != 0 && (MODULUS < 2 || MODULUS > (1 << WIDTH))) begin : g_bad_mod
            $error("mod_n_sync_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
        end
        if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_sat
            $error("mod_n_sync_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] fast_toggle;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             force_d;
    logic             load_err_d;
    logic             load_err_q;
    logic             at_term;

    assign at_term = up_dn ? (count_q == MAX_VAL) : (count_q == '0);
    assign tc      = en & at_term;

    always_comb begin
        nxt_d      = count_q;
        force_d    = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            // A rejected load still forces the cells so they hold, ignoring en.
            force_d = 1'b1;
            if (load_val <= MAX_VAL) begin
                nxt_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (count_q > MAX_VAL) begin
                nxt_d   = '0;
                force_d = 1'b1;
            end else if (up_dn) begin
                if (count_q == MAX_VAL) begin
                    nxt_d = (SATURATE == CNT_SAT) ? count_q : '0;
                end else begin
                    nxt_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    nxt_d = (SATURATE == CNT_SAT) ? count_q : MAX_VAL;
                end else begin
                    nxt_d = count_q - 1'b1;
                end
            end
        end
    end

    // Ripple-free binary toggle terms; terminal values take the exact toggle set instead.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == 0) begin : g_lsb
                assign fast_toggle[i] = en;
            end else begin : g_upper
                assign fast_toggle[i] = en & (up_dn ? (&count_q[i-1:0]) : ~(|count_q[i-1:0]));
            end

            assign toggle[i] = tc ? (count_q[i] ^ nxt_d[i]) : fast_toggle[i];
            assign j_vec[i]  = force_d ? nxt_d[i]  : toggle[i];
            assign k_vec[i]  = force_d ? ~nxt_d[i] : toggle[i];

            mod_n_sync_counter_jk_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (j_vec[i]),
                .k     (k_vec[i]),
                .q     (count_q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_sync_counter.sv
// Bench for three counter configurations sharing one stimulus stream:
// wrap mod-10, saturate mod-10, and full-range 3-bit wrap.
module tb_mod_n_sync_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_w, cnt_s;
    logic [2:0] cnt_b;
    logic       tc_w, tc_s, tc_b;
    logic       err_w, err_s, err_b;

    int n_vec;
    int n_err;

    int m_cnt [3];
    int mods  [3] = '{10, 10, 8};
    bit sats  [3] = '{1'b0, 1'b1, 1'b0};
    string names [3] = '{"wrap", "sat", "bin"};

    logic [4:0] exp_q[$];

    mod_n_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_w), .tc(tc_w), .load_err(err_w)
    );

    mod_n_sync_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_s), .tc(tc_s), .load_err(err_s)
    );

    mod_n_sync_counter #(.WIDTH(3), .MODULUS(0), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[2:0]), .count(cnt_b), .tc(tc_b), .load_err(err_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_out(input int k);
        case (k)
            0:       return {err_w, cnt_w};
            1:       return {err_s, cnt_s};
            default: return {err_b, 1'b0, cnt_b};
        endcase
    endfunction

    function automatic logic dut_tc(input int k);
        case (k)
            0:       return tc_w;
            1:       return tc_s;
            default: return tc_b;
        endcase
    endfunction

    // driver: one clock per call, with scoreboard push before the edge and pop after
    task automatic step(input bit rst, input bit e, input bit ud, input bit ld, input int lv);
        int nxt [3];
        bit nerr [3];
        int lvk;
        logic [4:0] got;
        logic [4:0] exp;
        @(negedge clk);
        reset    = rst;
        en       = e;
        up_dn    = ud;
        load     = ld;
        load_val = lv[3:0];
        #1;
        for (int k = 0; k < 3; k++) begin
            bit exp_tc;
            exp_tc = e && (ud ? (m_cnt[k] == mods[k] - 1) : (m_cnt[k] == 0));
            check({names[k], ".tc"}, {31'd0, dut_tc(k)}, {31'd0, exp_tc});

            lvk     = (k == 2) ? (lv & 7) : (lv & 15);
            nxt[k]  = m_cnt[k];
            nerr[k] = 1'b0;
            if (rst) begin
                nxt[k] = 0;
            end else if (ld) begin
                if (lvk < mods[k]) nxt[k] = lvk;
                else               nerr[k] = 1'b1;
            end else if (e) begin
                if (m_cnt[k] >= mods[k])          nxt[k] = 0;
                else if (ud) begin
                    if (m_cnt[k] == mods[k] - 1)  nxt[k] = sats[k] ? m_cnt[k] : 0;
                    else                          nxt[k] = m_cnt[k] + 1;
                end else begin
                    if (m_cnt[k] == 0)            nxt[k] = sats[k] ? 0 : mods[k] - 1;
                    else                          nxt[k] = m_cnt[k] - 1;
                end
            end
            exp_q.push_back({nerr[k], nxt[k][3:0]});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            got = dut_out(k);
            check({names[k], ".count"}, {28'd0, got[3:0]}, {28'd0, exp[3:0]});
            check({names[k], ".load_err"}, {31'd0, got[4]}, {31'd0, exp[4]});
            m_cnt[k] = nxt[k];
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;

        // reset held two cycles
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // count up through a full wrap
        for (int n = 0; n < 12; n++) step(0, 1, 1, 0, 0);

        // reset pulse mid-count with load and en also active
        step(0, 0, 1, 1, 7);
        step(1, 1, 1, 1, 3);

        // count down from 0
        for (int n = 0; n < 12; n++) step(0, 1, 0, 0, 0);

        // good load, then count, then out-of-range load and recovery
        step(0, 1, 1, 1, 5);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 12);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // en toggling at 3, then direction flip at 4
        step(0, 0, 1, 1, 3);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);

        // drive to the ends so the saturating instance holds there
        for (int n = 0; n < 12; n++) step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int n = 0; n < 12; n++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 15));
        end

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
